// File: rtl/if_prefetch_queue.sv
// Instruction prefetch: sequential fetch over a req/ack imem port into a DEPTH-entry {pc,ins} FIFO.
// A zero-wait ack reaches IR the next cycle; fetch pauses when full, stall holds the head, Flash discards.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CW       = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          stall,
  input  logic          Flash,
  input  logic [31:0]   redirectPC,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_data,
  output logic          valid,
  output logic [31:0]   IRIns,
  output logic [31:0]   IRPC,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {RUN = 1'b0, DISCARD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          req, push, pop, clear, has_entry;

  assign has_entry = (count_q != '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_addr_d = pend_addr_q;
    req         = 1'b0;
    imem_addr   = fetch_pc_q;
    push        = 1'b0;
    pop         = 1'b0;
    clear       = 1'b0;

    // In RUN the request can only rise when not full, and count cannot grow while it waits,
    // so the request and its address stay stable until the ack.
    case (state_q)
      RUN: req = (count_q < CW'(DEPTH));
      DISCARD: begin
        req       = 1'b1;
        imem_addr = pend_addr_q;
      end
    endcase

    if (Flash) begin
      clear      = 1'b1;
      fetch_pc_d = redirectPC;
      if (state_q == RUN && req && !imem_ack) begin
        pend_addr_d = fetch_pc_q;
        state_d     = DISCARD;
      end else if (state_q == DISCARD && imem_ack) begin
        state_d = RUN;
      end
    end else begin
      pop = has_entry && !stall;
      if (state_q == RUN) begin
        if (req && imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end else if (imem_ack) begin
        state_d = RUN;
      end
    end
  end

  // Reset gates the request so an in-flight transaction is abandoned immediately.
  assign imem_req = RST & req;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc_q  <= RESET_PC;
      pend_addr_q <= 32'h0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_addr_q <= pend_addr_d;
      if (clear) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push && !pop) begin
          count_q <= count_q + CW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= 32'h0;
        ins_mem[i] <= 32'h0;
      end
    end else if (push) begin
      pc_mem[wr_ptr_q]  <= fetch_pc_q;
      ins_mem[wr_ptr_q] <= imem_data;
    end
  end

  assign valid = has_entry;
  assign IRIns = has_entry ? ins_mem[rd_ptr_q] : 32'h0;
  assign IRPC  = has_entry ? pc_mem[rd_ptr_q]  : 32'h0;
  assign count = count_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: behavioural imem responder plus a {pc,ins} scoreboard checked every cycle.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          stall = 1'b0;
  logic          Flash = 1'b0;
  logic [31:0]   redirectPC = 32'h0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_data = 32'h0;
  logic          valid;
  logic [31:0]   IRIns;
  logic [31:0]   IRPC;
  logic [CW-1:0] count;

  int          checks = 0;
  int          failures = 0;
  ent_t        q[$];
  bit          disc = 0;
  int          wait_cnt = 0;
  int          lat = 0;
  int          n_pops = 0;
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] dx = 32'h0;
  logic [31:0] last_pop_pc = 32'h0;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .Flash(Flash), .redirectPC(redirectPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .valid(valid), .IRIns(IRIns), .IRPC(IRPC), .count(count)
  );

  always #5 CLK = ~CLK;

  // Called at negedge+1: compare outputs to the model, answer the request, advance model, step one clock.
  task automatic cycle();
    logic          acked;
    logic          exp_req;
    logic [CW-1:0] exp_cnt;
    ent_t          e;
    exp_cnt = CW'(q.size());
    checks++;
    if (q.size() == 0) begin
      if (valid !== 1'b0 || IRPC !== 32'h0 || IRIns !== 32'h0) begin
        failures++;
        $display("FAIL sb_empty valid=%b pc=%h ins=%h expected 0/0/0", valid, IRPC, IRIns);
      end
    end else if (valid !== 1'b1 || IRPC !== q[0].pc || IRIns !== q[0].ins) begin
      failures++;
      $display("FAIL sb_head valid=%b pc=%h ins=%h expected 1 pc=%h ins=%h",
               valid, IRPC, IRIns, q[0].pc, q[0].ins);
    end
    checks++;
    if (count !== exp_cnt) begin
      failures++;
      $display("FAIL sb_count got=%0d expected=%0d", count, exp_cnt);
    end
    exp_req = disc || (q.size() < DEPTH);
    checks++;
    if (imem_req !== exp_req) begin
      failures++;
      $display("FAIL sb_req got=%b expected=%b", imem_req, exp_req);
    end
    if (imem_req === 1'b1 && !disc) begin
      checks++;
      if (imem_addr !== exp_fetch) begin
        failures++;
        $display("FAIL sb_addr got=%h expected=%h", imem_addr, exp_fetch);
      end
    end
    if (wait_cnt > 0) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== held_addr) begin
        failures++;
        $display("FAIL req_hold req=%b addr=%h expected 1 addr=%h", imem_req, imem_addr, held_addr);
      end
    end

    acked = 1'b0;
    if (imem_req === 1'b1) begin
      if (wait_cnt == 0) held_addr = imem_addr;
      if (wait_cnt >= lat) begin
        acked     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = imem_addr ^ dx;
        wait_cnt  = 0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 32'hBAD0_BAD0;
        wait_cnt++;
      end
    end else begin
      imem_ack  = 1'b0;
      imem_data = 32'h0;
      wait_cnt  = 0;
    end

    if (Flash) begin
      q.delete();
      exp_fetch = redirectPC;
    end else begin
      if (q.size() > 0 && !stall) begin
        e = q.pop_front();
        last_pop_pc = e.pc;
        n_pops++;
      end
      if (acked && !disc) begin
        checks++;
        if (q.size() >= DEPTH) begin
          failures++;
          $display("FAIL push_full size=%0d expected below %0d", q.size(), DEPTH);
        end
        e.pc  = imem_addr;
        e.ins = imem_addr ^ dx;
        q.push_back(e);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    disc = Flash ? (imem_req === 1'b1 && !acked) : (disc && !acked);

    @(posedge CLK);
    @(negedge CLK);
    #1;
    imem_ack = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0; stall = 1'b0; Flash = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
    q.delete(); disc = 0; wait_cnt = 0; exp_fetch = 32'h0; n_pops = 0; last_pop_pc = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || valid !== 1'b0 || count !== '0 ||
        IRIns !== 32'h0 || IRPC !== 32'h0) begin
      failures++;
      $display("FAIL reset_state req=%b addr=%h valid=%b count=%0d ins=%h pc=%h expected all 0",
               imem_req, imem_addr, valid, count, IRIns, IRPC);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_release req=%b addr=%h expected 1 addr=0", imem_req, imem_addr);
    end
    lat = 0; dx = 32'h0; stall = 1'b1;
    repeat (3) cycle();
    RST = 1'b0;
    #1;
    checks++;
    if (count !== '0 || valid !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_async count=%0d valid=%b req=%b expected 0/0/0", count, valid, imem_req);
    end
  endtask

  task automatic test_boot();
    logic [31:0] a[3];
    logic        v[3];
    logic [31:0] p[3];
    logic [31:0] d[3];
    apply_reset();
    lat = 0; dx = 32'h0; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a[i] = imem_addr; v[i] = valid; p[i] = IRPC; d[i] = IRIns;
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL boot_addr%0d got=%h expected=%h", i, a[i], 32'(4 * i));
      end
    end
    checks++;
    if (v[0] !== 1'b0 || v[1] !== 1'b1 || p[1] !== 32'h0 || d[1] !== 32'h0) begin
      failures++;
      $display("FAIL boot_first v0=%b v1=%b pc=%h ins=%h expected 0 1 0 0", v[0], v[1], p[1], d[1]);
    end
  endtask

  task automatic test_fill_stall();
    apply_reset();
    lat = 0; dx = 32'hDEAD_0000; stall = 1'b1;
    repeat (6) cycle();
    checks++;
    if (count !== CW'(DEPTH) || imem_req !== 1'b0 || IRPC !== 32'h0) begin
      failures++;
      $display("FAIL fill_full count=%0d req=%b pc=%h expected %0d 0 0", count, imem_req, IRPC, DEPTH);
    end
    stall = 1'b0;
    cycle();
    stall = 1'b1;
    checks++;
    if (IRPC !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL fill_pop pc=%h req=%b addr=%h expected 4 1 10", IRPC, imem_req, imem_addr);
    end
    cycle();
  endtask

  task automatic test_var_latency();
    apply_reset();
    lat = 3; dx = 32'h1234_0000; stall = 1'b0;
    repeat (30) cycle();
    checks++;
    if (n_pops != 7 || last_pop_pc !== 32'h18) begin
      failures++;
      $display("FAIL varlat_pops got=%0d last=%h expected 7 last=18", n_pops, last_pop_pc);
    end
  endtask

  task automatic test_flash_pending();
    int n;
    apply_reset();
    lat = 3; dx = 32'h5A5A_0000; stall = 1'b1;
    n = 0;
    while (imem_addr !== 32'h8 && n < 40) begin cycle(); n++; end
    cycle();
    Flash = 1'b1; redirectPC = 32'h100;
    cycle();
    Flash = 1'b0;
    checks++;
    if (count !== '0 || valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL flashp_after count=%0d valid=%b req=%b addr=%h expected 0 0 1 8",
               count, valid, imem_req, imem_addr);
    end
    n = 0;
    while (imem_addr === 32'h8 && n < 10) begin cycle(); n++; end
    checks++;
    if (imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL flashp_redirect addr=%h expected 100", imem_addr);
    end
    stall = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin cycle(); n++; end
    checks++;
    if (valid !== 1'b1 || IRPC !== 32'h100) begin
      failures++;
      $display("FAIL flashp_first valid=%b pc=%h expected 1 100", valid, IRPC);
    end
  endtask

  task automatic test_flash_ack();
    int n;
    bit seen_c;
    apply_reset();
    lat = 0; dx = 32'h0F0F_0000; stall = 1'b1;
    n = 0;
    while (imem_addr !== 32'hC && n < 10) begin cycle(); n++; end
    Flash = 1'b1; redirectPC = 32'h40;
    cycle();
    Flash = 1'b0;
    checks++;
    if (imem_addr !== 32'h40 || valid !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL flasha_after addr=%h valid=%b count=%0d expected 40 0 0", imem_addr, valid, count);
    end
    stall = 1'b0;
    seen_c = 0;
    repeat (8) begin
      if (valid === 1'b1 && IRPC === 32'hC) seen_c = 1;
      cycle();
    end
    checks++;
    if (seen_c || last_pop_pc !== 32'h58) begin
      failures++;
      $display("FAIL flasha_drop seen_c=%0d last=%h expected 0 last=58", seen_c, last_pop_pc);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] prev;
    apply_reset();
    lat = 0; dx = 32'hC0DE_0000; stall = 1'b1;
    n = 0;
    while (count !== CW'(2) && n < 10) begin cycle(); n++; end
    stall = 1'b0;
    prev = IRPC;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cycle();
      checks++;
      if (count !== CW'(2) || IRPC !== prev + 32'd4) begin
        failures++;
        $display("FAIL b2b_step%0d count=%0d pc=%h expected 2 pc=%h", i, count, IRPC, prev + 32'd4);
      end
      prev = IRPC;
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_fill_stall();
    test_var_latency();
    test_flash_pending();
    test_flash_ack();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
